// File: rtl/hex_word_streamer.sv
// Streams binary words out as uppercase ASCII hex characters, MSB nibble first,
// with an optional separator after each word and an optional CR/LF every N words.
module hex_word_streamer #(
    parameter int unsigned NIBBLES        = 8,
    parameter bit          SEP_EN         = 1'b1,
    parameter logic [7:0]  SEP_CHAR       = 8'h20,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 busy
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned LC_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(NIBBLES - 1);
    localparam logic [LC_W-1:0]  LC_LAST  = (WORDS_PER_LINE > 0) ? LC_W'(WORDS_PER_LINE - 1) : '0;
    localparam bit               BREAK_EN = (WORDS_PER_LINE != 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIGIT = 3'd1,
        ST_SEP   = 3'd2,
        ST_CR    = 3'd3,
        ST_LF    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LC_W-1:0]   line_q, line_d;
    logic              in_ready_q, out_valid_q, busy_q;
    logic [7:0]        out_data_q;
    logic [7:0]        out_char_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h37 + {4'h0, nib};
        end
        return ch;
    endfunction

    function automatic logic [3:0] pick_nibble(input logic [W-1:0] word,
                                               input logic [IDX_W-1:0] idx);
        logic [W-1:0] shifted;
        shifted = word >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

    // Next-state logic for the sequencer, nibble index, word latch and line counter
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        line_d  = line_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d  = in_word;
                    idx_d   = IDX_MSB;
                    state_d = ST_DIGIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIGIT: begin
                if (!out_ready) begin
                    state_d = ST_DIGIT;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else if (BREAK_EN && (line_q == LC_LAST)) begin
                    // A line break takes the separator's place at end of line.
                    line_d  = '0;
                    state_d = ST_CR;
                end else begin
                    if (BREAK_EN) begin
                        line_d = line_q + 1'b1;
                    end else begin
                        line_d = line_q;
                    end
                    state_d = SEP_EN ? ST_SEP : ST_IDLE;
                end
            end
            ST_SEP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEP;
                end
            end
            ST_CR: begin
                if (out_ready) begin
                    state_d = ST_LF;
                end else begin
                    state_d = ST_CR;
                end
            end
            ST_LF: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Character that will be presented once the next state is entered
    always_comb begin
        out_char_s = 8'h00;
        case (state_d)
            ST_IDLE:  out_char_s = 8'h00;
            ST_DIGIT: out_char_s = hex_ascii(pick_nibble(word_d, idx_d));
            ST_SEP:   out_char_s = SEP_CHAR;
            ST_CR:    out_char_s = 8'h0D;
            ST_LF:    out_char_s = 8'h0A;
            default:  out_char_s = 8'h00;
        endcase
    end

    // State and registered handshake outputs; outputs never see inputs combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            line_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d != ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            out_data_q  <= out_char_s;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_hex_word_streamer.sv
// Bench for hex_word_streamer: two instances (4 and 2 words per line) checked
// against a character-queue model built from the hex/separator/line-break rules.
module tb_hex_word_streamer;

    localparam int NIB = 8;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_word   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [7:0]  out_data  [2];
    logic        busy      [2];

    int          errors = 0;
    int          checks = 0;
    int          wpl [2] = '{4, 2};
    int          lc  [2] = '{0, 0};
    logic [7:0]  expq [2][$];
    logic        stall_r [2] = '{1'b0, 1'b0};
    logic [7:0]  held_r  [2];
    string       hexs = "0123456789ABCDEF";

    always #5 clk = ~clk;

    hex_word_streamer #(.NIBBLES(8), .SEP_EN(1'b1), .SEP_CHAR(8'h20), .WORDS_PER_LINE(4)) dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_word(in_word[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0]));

    hex_word_streamer #(.NIBBLES(8), .SEP_EN(1'b1), .SEP_CHAR(8'h20), .WORDS_PER_LINE(2)) dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_word(in_word[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: append the characters a word should produce; returns trailer length.
    function automatic int push_word(input int d, input logic [31:0] w);
        for (int i = NIB - 1; i >= 0; i--) begin
            expq[d].push_back(8'(hexs[int'((w >> (4 * i)) & 32'hF)]));
        end
        if (wpl[d] != 0 && lc[d] == wpl[d] - 1) begin
            expq[d].push_back(8'h0D);
            expq[d].push_back(8'h0A);
            lc[d] = 0;
            return 2;
        end
        if (wpl[d] != 0) lc[d]++;
        expq[d].push_back(8'h20);
        return 1;
    endfunction

    // Character monitor: every transfer must match the model; stalls must hold
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) begin
                if (stall_r[d]) begin
                    chk($sformatf("hold_valid%0d", d), 32'(out_valid[d]), 32'd1);
                    chk($sformatf("hold_data%0d", d), 32'(out_data[d]), 32'(held_r[d]));
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (expq[d].size() == 0) begin
                        chk($sformatf("unexpected_char%0d", d), 32'(out_data[d]), 32'hFFFF_FFFF);
                    end else begin
                        chk($sformatf("char%0d", d), 32'(out_data[d]), 32'(expq[d].pop_front()));
                    end
                end
                stall_r[d] = out_valid[d] && !out_ready[d];
                held_r[d]  = out_data[d];
            end else begin
                stall_r[d] = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input int d);
        int n = 0;
        while (!in_ready[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("ready_timeout", 32'(in_ready[d]), 32'd1);
    endtask

    task automatic send(input int d, input logic [31:0] w, output int trail);
        wait_ready(d);
        in_word[d]  = w;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        trail = push_word(d, w);
        chk("first_digit_valid", 32'(out_valid[d]), 32'd1);
        chk("busy_after_accept", 32'(busy[d]), 32'd1);
        chk("ready_low_after_accept", 32'(in_ready[d]), 32'd0);
    endtask

    // Sends a word with out_ready=1 and checks the cycle cost until in_ready returns.
    task automatic run_word(input int d, input logic [31:0] w);
        int trail;
        int cnt;
        send(d, w, trail);
        cnt = 1;
        while (!in_ready[d] && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("word_cost", 32'(cnt), 32'(NIB + 1 + trail));
    endtask

    initial begin
        int trail;
        int n;
        logic [31:0] w;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; in_word[d] = 32'h0; out_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_in_ready", 32'(in_ready[d]), 32'd1);
            chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
            chk("reset_out_data", 32'(out_data[d]), 32'h00);
            chk("reset_busy", 32'(busy[d]), 32'd0);
            rst[d] = 1'b0;
        end

        // Basic words on the 4-per-line instance, then 1,2,3 on the 2-per-line one
        run_word(0, 32'h1234ABCD);
        run_word(0, 32'h00000000);
        run_word(0, 32'hFFFFFFFF);
        run_word(1, 32'h00000001);
        run_word(1, 32'h00000002);
        run_word(1, 32'h00000003);

        // Reset after the third digit: abort word and discard the line count
        send(0, 32'h89ABCDEF, trail);
        repeat (3) begin @(posedge clk); #1; end
        out_ready[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_out_data", 32'(out_data[0]), 32'h00);
        rst[0] = 1'b0;
        expq[0].delete();
        lc[0] = 0;
        @(posedge clk); #1;
        chk("postrst_idle_valid", 32'(out_valid[0]), 32'd0);

        // Random backpressure on DEADBEEF
        send(0, 32'hDEADBEEF, trail);
        n = 0;
        while ((expq[0].size() != 0 || !in_ready[0]) && n < 300) begin
            out_ready[0] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("backpressure_done", 32'(expq[0].size()), 32'd0);
        out_ready[0] = 1'b1;

        // in_valid held high with changing in_word: only IDLE-cycle words print
        wait_ready(0);
        in_valid[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("held_idle_ready", 32'(in_ready[0]), 32'd1);
            w = $urandom;
            in_word[0] = w;
            @(posedge clk); #1;
            trail = push_word(0, w);
            for (int j = 0; j < NIB + trail; j++) begin
                chk("held_busy_ready", 32'(in_ready[0]), 32'd0);
                in_word[0] = $urandom;
                @(posedge clk); #1;
            end
        end
        in_valid[0] = 1'b0;

        // Random words on both instances, some under backpressure
        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < 2; d++) begin
                send(d, $urandom, trail);
                n = 0;
                while ((expq[d].size() != 0 || !in_ready[d]) && n < 300) begin
                    out_ready[d] = (k % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    n++;
                end
                out_ready[d] = 1'b1;
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        for (int d = 0; d < 2; d++) begin
            chk("queue_drained", 32'(expq[d].size()), 32'd0);
            chk("final_idle", 32'(in_ready[d]), 32'd1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
